// File: rtl/reservation_station_pkg.sv
// Shared ROB id width, operand/entry record types and the all-operands-ready helper.
`ifndef ROB_QUEUE_BITS
`define ROB_QUEUE_BITS 4
`endif

package reservation_station_pkg;

  localparam int RQB      = `ROB_QUEUE_BITS;
  localparam int RS_N_OPS = 3;

  typedef struct packed {
    logic [15:0]    val;
    logic [RQB-1:0] tag;
    logic           rdy;
  } rs_op_t;

  typedef struct packed {
    logic                    vld;
    logic [RQB-1:0]          uid;
    rs_op_t [RS_N_OPS-1:0]   ops;
  } rs_entry_t;

  function automatic logic ops_ready(input rs_op_t [RS_N_OPS-1:0] ops);
    logic r;
    r = 1'b1;
    for (int j = 0; j < RS_N_OPS; j++) r = r & ops[j].rdy;
    return r;
  endfunction

endpackage

// File: rtl/rs_pick_lowest.sv
// Priority encoder: index of the lowest set request bit; combinational, no backpressure.
module rs_pick_lowest #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    found_o = |req_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Operand-waiting RS with CDB wakeup; dispatch/wakeup to issue is 2 cycles.
// Dispatch is refused while full; the FU always accepts, so issue never stalls.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_DEPTH = 4,
  parameter int N_OPS    = RS_N_OPS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        dispatch_valid,
  input  logic [RQB-1:0]              dispatch_uid,
  input  logic [N_OPS-1:0][15:0]      dispatch_params,
  input  logic [N_OPS-1:0][RQB-1:0]   dispatch_tags,
  input  logic [N_OPS-1:0]            dispatch_ready,
  output logic                        dispatch_full,
  input  logic                        cdb_valid,
  input  logic [RQB-1:0]              cdb_uid,
  input  logic [15:0]                 cdb_val,
  output logic                        has_outgoing,
  output logic [RQB-1:0]              out_uid,
  output logic [N_OPS-1:0][15:0]      out_params
);

  localparam int IW = $clog2(RS_DEPTH);

  rs_entry_t [RS_DEPTH-1:0] ent_q, ent_d;
  logic                     has_q, has_d;
  logic [RQB-1:0]           out_uid_q, out_uid_d;
  logic [N_OPS-1:0][15:0]   out_params_q, out_params_d;

  logic [RS_DEPTH-1:0] free_vec, elig_vec;
  logic                alloc_found, iss_found;
  logic [IW-1:0]       alloc_idx, iss_idx;

  // Eligibility looks only at registered ready bits: a CDB hit this cycle issues next cycle.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      free_vec[i] = !ent_q[i].vld;
      elig_vec[i] = ent_q[i].vld && ops_ready(ent_q[i].ops);
    end
  end

  rs_pick_lowest #(.N(RS_DEPTH), .IW(IW)) u_pick_free (
    .req_i   (free_vec),
    .found_o (alloc_found),
    .idx_o   (alloc_idx)
  );

  rs_pick_lowest #(.N(RS_DEPTH), .IW(IW)) u_pick_issue (
    .req_i   (elig_vec),
    .found_o (iss_found),
    .idx_o   (iss_idx)
  );

  assign dispatch_full = !alloc_found;

  always_comb begin
    logic hit;
    ent_d        = ent_q;
    has_d        = 1'b0;
    out_uid_d    = out_uid_q;
    out_params_d = out_params_q;
    hit          = 1'b0;

    if (cdb_valid) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        for (int j = 0; j < N_OPS; j++) begin
          if (ent_q[i].vld && !ent_q[i].ops[j].rdy && ent_q[i].ops[j].tag == cdb_uid) begin
            ent_d[i].ops[j].rdy = 1'b1;
            ent_d[i].ops[j].val = cdb_val;
          end
        end
      end
    end

    if (iss_found) begin
      has_d     = 1'b1;
      out_uid_d = ent_q[iss_idx].uid;
      for (int j = 0; j < N_OPS; j++) out_params_d[j] = ent_q[iss_idx].ops[j].val;
      ent_d[iss_idx].vld = 1'b0;
    end

    // The allocated slot is free and the issued one valid, so these never collide.
    if (dispatch_valid && alloc_found) begin
      ent_d[alloc_idx].vld = 1'b1;
      ent_d[alloc_idx].uid = dispatch_uid;
      for (int j = 0; j < N_OPS; j++) begin
        hit = cdb_valid && (dispatch_tags[j] == cdb_uid);
        ent_d[alloc_idx].ops[j].tag = dispatch_tags[j];
        ent_d[alloc_idx].ops[j].rdy = dispatch_ready[j] | hit;
        ent_d[alloc_idx].ops[j].val = (!dispatch_ready[j] && hit) ? cdb_val : dispatch_params[j];
      end
    end

    if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_d[i].vld = 1'b0;
      has_d        = 1'b0;
      out_uid_d    = out_uid_q;
      out_params_d = out_params_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q        <= '0;
      has_q        <= 1'b0;
      out_uid_q    <= '0;
      out_params_q <= '0;
    end else begin
      ent_q        <= ent_d;
      has_q        <= has_d;
      out_uid_q    <= out_uid_d;
      out_params_q <= out_params_d;
    end
  end

  assign has_outgoing = has_q;
  assign out_uid      = out_uid_q;
  assign out_params   = out_params_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue latency, wakeup, full, ordering, flush, reset.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int NO = 3;

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic                    dispatch_valid;
  logic [RQB-1:0]          dispatch_uid;
  logic [NO-1:0][15:0]     dispatch_params;
  logic [NO-1:0][RQB-1:0]  dispatch_tags;
  logic [NO-1:0]           dispatch_ready;
  logic                    dispatch_full;
  logic                    cdb_valid;
  logic [RQB-1:0]          cdb_uid;
  logic [15:0]             cdb_val;
  logic                    has_outgoing;
  logic [RQB-1:0]          out_uid;
  logic [NO-1:0][15:0]     out_params;

  int checks;
  int failures;

  reservation_station #(.RS_DEPTH(4), .N_OPS(NO)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .dispatch_valid  (dispatch_valid),
    .dispatch_uid    (dispatch_uid),
    .dispatch_params (dispatch_params),
    .dispatch_tags   (dispatch_tags),
    .dispatch_ready  (dispatch_ready),
    .dispatch_full   (dispatch_full),
    .cdb_valid       (cdb_valid),
    .cdb_uid         (cdb_uid),
    .cdb_val         (cdb_val),
    .has_outgoing    (has_outgoing),
    .out_uid         (out_uid),
    .out_params      (out_params)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    flush           = 1'b0;
    dispatch_valid  = 1'b0;
    dispatch_uid    = '0;
    dispatch_params = '0;
    dispatch_tags   = '0;
    dispatch_ready  = '0;
    cdb_valid       = 1'b0;
    cdb_uid         = '0;
    cdb_val         = '0;
  endtask

  task automatic set_disp(input logic [RQB-1:0] uid, input logic [15:0] p0, input logic [15:0] p1,
                          input logic [15:0] p2, input logic [NO-1:0] rdy, input logic [RQB-1:0] tag);
    dispatch_valid  = 1'b1;
    dispatch_uid    = uid;
    dispatch_params = {p2, p1, p0};
    dispatch_tags   = {tag, tag, tag};
    dispatch_ready  = rdy;
  endtask

  task automatic set_cdb(input logic [RQB-1:0] uid, input logic [15:0] val);
    cdb_valid = 1'b1;
    cdb_uid   = uid;
    cdb_val   = val;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #1;
    checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL reset_has got=%b exp=0", has_outgoing); end
    checks++; if (out_uid !== '0) begin failures++; $display("FAIL reset_uid got=%0d exp=0", out_uid); end
    checks++; if (out_params !== '0) begin failures++; $display("FAIL reset_params got=%h exp=0", out_params); end
    checks++; if (dispatch_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", dispatch_full); end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_ready_dispatch();
    set_disp(5, 16'h0012, 16'h0034, 16'h0056, 3'b111, 0);
    step(); idle();
    checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL ready_c1_has got=%b exp=0", has_outgoing); end
    step();
    checks++; if (has_outgoing !== 1'b1) begin failures++; $display("FAIL ready_c2_has got=%b exp=1", has_outgoing); end
    checks++; if (out_uid !== 4'd5) begin failures++; $display("FAIL ready_c2_uid got=%0d exp=5", out_uid); end
    checks++; if (out_params !== {16'h0056, 16'h0034, 16'h0012}) begin failures++; $display("FAIL ready_c2_params got=%h exp=005600340012", out_params); end
    step();
    checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL ready_c3_has got=%b exp=0", has_outgoing); end
    checks++; if (out_uid !== 4'd5) begin failures++; $display("FAIL ready_hold_uid got=%0d exp=5", out_uid); end
    checks++; if (out_params !== {16'h0056, 16'h0034, 16'h0012}) begin failures++; $display("FAIL ready_hold_params got=%h exp=005600340012", out_params); end
  endtask

  task automatic test_cdb_wakeup();
    set_disp(2, 16'h000A, 16'h0000, 16'h000C, 3'b101, 7);
    step(); idle();
    step();
    checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL wake_early_has got=%b exp=0", has_outgoing); end
    step();
    set_cdb(7, 16'hBEEF);
    step(); idle();
    checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL wake_c4_has got=%b exp=0", has_outgoing); end
    step();
    checks++; if (has_outgoing !== 1'b1) begin failures++; $display("FAIL wake_c5_has got=%b exp=1", has_outgoing); end
    checks++; if (out_uid !== 4'd2) begin failures++; $display("FAIL wake_c5_uid got=%0d exp=2", out_uid); end
    checks++; if (out_params !== {16'h000C, 16'hBEEF, 16'h000A}) begin failures++; $display("FAIL wake_c5_params got=%h exp=000cbeef000a", out_params); end
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      set_disp(RQB'(i + 1), 16'h0100, 16'h0200, 16'h0300, 3'b110, RQB'(10 + i));
      step();
    end
    idle();
    checks++; if (dispatch_full !== 1'b1) begin failures++; $display("FAIL full_set got=%b exp=1", dispatch_full); end
    set_disp(6, 16'h0006, 16'h0006, 16'h0006, 3'b111, 0);
    step(); idle();
    checks++; if (dispatch_full !== 1'b1) begin failures++; $display("FAIL full_hold got=%b exp=1", dispatch_full); end
    set_cdb(12, 16'h2222);
    step(); idle();
    checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL full_w1_has got=%b exp=0", has_outgoing); end
    checks++; if (dispatch_full !== 1'b1) begin failures++; $display("FAIL full_w1_full got=%b exp=1", dispatch_full); end
    set_disp(8, 16'h0008, 16'h0008, 16'h0008, 3'b111, 0);
    step(); idle();
    checks++; if (has_outgoing !== 1'b1 || out_uid !== 4'd3) begin failures++; $display("FAIL full_issue got has=%b uid=%0d exp has=1 uid=3", has_outgoing, out_uid); end
    checks++; if (out_params[0] !== 16'h2222) begin failures++; $display("FAIL full_issue_p0 got=%h exp=2222", out_params[0]); end
    checks++; if (dispatch_full !== 1'b0) begin failures++; $display("FAIL full_clear got=%b exp=0", dispatch_full); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL full_ignored cyc=%0d got has=%b uid=%0d exp has=0", k, has_outgoing, out_uid); end
    end
    flush = 1'b1;
    step(); idle();
  endtask

  task automatic test_same_cycle();
    set_disp(1, 16'h0001, 16'h0002, 16'h0003, 3'b011, 9);
    set_cdb(9, 16'h1111);
    step(); idle();
    checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL same_c1_has got=%b exp=0", has_outgoing); end
    step();
    checks++; if (has_outgoing !== 1'b1 || out_uid !== 4'd1) begin failures++; $display("FAIL same_c2 got has=%b uid=%0d exp has=1 uid=1", has_outgoing, out_uid); end
    checks++; if (out_params !== {16'h1111, 16'h0002, 16'h0001}) begin failures++; $display("FAIL same_c2_params got=%h exp=111100020001", out_params); end
    step();
  endtask

  task automatic test_order();
    set_disp(1, 16'h0001, 16'h0, 16'h0, 3'b110, 11); step();
    set_disp(2, 16'h0002, 16'h0, 16'h0, 3'b110, 13); step();
    set_disp(3, 16'h0003, 16'h0, 16'h0, 3'b110, 12); step();
    set_disp(4, 16'h0004, 16'h0, 16'h0, 3'b110, 13); step();
    idle();
    set_cdb(13, 16'h3333);
    step(); idle();
    checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL order_w1_has got=%b exp=0", has_outgoing); end
    step();
    checks++; if (has_outgoing !== 1'b1 || out_uid !== 4'd2 || out_params[0] !== 16'h3333) begin failures++; $display("FAIL order_first got has=%b uid=%0d p0=%h exp has=1 uid=2 p0=3333", has_outgoing, out_uid, out_params[0]); end
    step();
    checks++; if (has_outgoing !== 1'b1 || out_uid !== 4'd4 || out_params[0] !== 16'h3333) begin failures++; $display("FAIL order_second got has=%b uid=%0d p0=%h exp has=1 uid=4 p0=3333", has_outgoing, out_uid, out_params[0]); end
    step();
    checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL order_done got=%b exp=0", has_outgoing); end
    flush = 1'b1;
    step(); idle();
  endtask

  task automatic test_flush();
    set_disp(1, 16'h0, 16'h0, 16'h0, 3'b110, 15); step();
    set_disp(2, 16'h0, 16'h0, 16'h0, 3'b110, 15); step();
    set_disp(3, 16'h0777, 16'h0777, 16'h0777, 3'b111, 0); step();
    set_disp(7, 16'h0007, 16'h0007, 16'h0007, 3'b111, 0);
    set_cdb(15, 16'h5555);
    flush = 1'b1;
    step(); idle();
    checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL flush_has got=%b uid=%0d exp=0", has_outgoing, out_uid); end
    checks++; if (dispatch_full !== 1'b0) begin failures++; $display("FAIL flush_full got=%b exp=0", dispatch_full); end
    set_cdb(15, 16'h5555);
    step(); idle();
    for (int k = 0; k < 2; k++) begin
      checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL flush_stale cyc=%0d got has=%b uid=%0d exp has=0", k, has_outgoing, out_uid); end
      step();
    end
    set_disp(5, 16'h0505, 16'h0505, 16'h0505, 3'b111, 0);
    step(); idle(); step();
    checks++; if (has_outgoing !== 1'b1 || out_uid !== 4'd5) begin failures++; $display("FAIL flush_after got has=%b uid=%0d exp has=1 uid=5", has_outgoing, out_uid); end
    step();
  endtask

  task automatic test_rst_mid();
    set_disp(10, 16'h0, 16'h0, 16'h0, 3'b110, 15); step();
    set_disp(11, 16'h0, 16'h0, 16'h0, 3'b110, 15); step();
    set_disp(9, 16'h0909, 16'h0909, 16'h0909, 3'b111, 0); step();
    set_disp(12, 16'h0C0C, 16'h0C0C, 16'h0C0C, 3'b111, 0); step();
    idle();
    checks++; if (has_outgoing !== 1'b1 || out_uid !== 4'd9) begin failures++; $display("FAIL rst_pre got has=%b uid=%0d exp has=1 uid=9", has_outgoing, out_uid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (has_outgoing !== 1'b0 || out_uid !== '0 || out_params !== '0) begin failures++; $display("FAIL rst_async got has=%b uid=%0d params=%h exp all 0", has_outgoing, out_uid, out_params); end
    checks++; if (dispatch_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", dispatch_full); end
    step(); step();
    rst = 1'b0;
    set_cdb(15, 16'h6666);
    step(); idle();
    for (int k = 0; k < 2; k++) begin
      checks++; if (has_outgoing !== 1'b0) begin failures++; $display("FAIL rst_stale cyc=%0d got has=%b uid=%0d exp has=0", k, has_outgoing, out_uid); end
      step();
    end
    set_disp(4, 16'h0404, 16'h0404, 16'h0404, 3'b111, 0);
    step(); idle(); step();
    checks++; if (has_outgoing !== 1'b1 || out_uid !== 4'd4) begin failures++; $display("FAIL rst_after got has=%b uid=%0d exp has=1 uid=4", has_outgoing, out_uid); end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ready_dispatch();
    test_cdb_wakeup();
    test_full();
    test_same_cycle();
    test_order();
    test_flush();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
